// File: rtl/pipe_reg_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer and a registered in_ready.
// A flush or reset always leaves zero control payload, so downstream only ever sees a NOP.
module pipe_reg_skid #(
    parameter int DATA_W              = 128,
    parameter int CTRL_W              = 16,
    parameter int CLEAR_DATA_ON_FLUSH = 0,
    parameter int CNT_W               = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              acc;
    logic              cons;

    always_comb begin
        acc         = in_valid & ~skid_v_q & ~hold;
        cons        = main_v_q & out_ready & ~hold;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        bubble_d    = bubble_q;

        if (!main_v_q && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end

        if (flush) begin
            // Flush wins over hold and drops any beat presented this cycle.
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_ON_FLUSH != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (skid_v_q) begin
            if (cons) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
                skid_ctrl_d = '0;
            end
        end else if (main_v_q) begin
            if (acc && cons) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (acc) begin
                skid_v_d    = 1'b1;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end else if (cons) begin
                main_v_d    = 1'b0;
                main_ctrl_d = '0;
            end
        end else if (acc) begin
            main_v_d    = 1'b1;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            bubble_q    <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            bubble_q    <= bubble_d;
        end
    end

    generate
        if (CLEAR_DATA_ON_FLUSH != 0) begin : g_data_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    endgenerate

    assign in_ready   = ~skid_v_q;
    assign out_valid  = main_v_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign occupancy  = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: accepted beats are queued and compared as they
// leave the stage, while a small occupancy/bubble model checks the control outputs.
module tb_pipe_reg_skid;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    logic [NW-1:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int m_occ = 0;
    int m_bub = 0;
    logic [DW+CW-1:0] sb[$];

    pipe_reg_skid #(
        .DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .hold(hold), .flush(flush), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sb.delete();
        m_occ = 0;
        m_bub = 0;
    endtask

    // Inputs are already driven; advance one clock and check state against the model.
    task automatic cycle(output bit accepted);
        bit acc, cons, was_flush;
        logic [DW+CW-1:0] exp;
        acc       = in_valid && (m_occ < 2) && !hold && !flush;
        cons      = (m_occ > 0) && out_ready && !hold;
        was_flush = flush;
        if (cons) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL consume_underflow: got beat %h, expected no beat", {out_data, out_ctrl});
            end else begin
                exp = sb.pop_front();
                if ({out_data, out_ctrl} !== exp) begin
                    n_errors++;
                    $display("FAIL consume_beat: got %h, expected %h", {out_data, out_ctrl}, exp);
                end else begin
                    $display("beat out data=%h ctrl=%h", out_data, out_ctrl);
                end
            end
        end
        if (m_occ == 0 && m_bub != 15) m_bub++;
        if (was_flush) begin
            sb.delete();
            m_occ = 0;
        end else begin
            m_occ = m_occ + int'(acc) - int'(cons);
            if (acc) sb.push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== (m_occ > 0)) begin
            n_errors++;
            $display("FAIL out_valid: got %b, expected %b", out_valid, m_occ > 0);
        end
        n_checks++;
        if (in_ready !== (m_occ < 2)) begin
            n_errors++;
            $display("FAIL in_ready: got %b, expected %b", in_ready, m_occ < 2);
        end
        n_checks++;
        if (occupancy !== 2'(m_occ)) begin
            n_errors++;
            $display("FAIL occupancy: got %0d, expected %0d", occupancy, m_occ);
        end
        n_checks++;
        if (bubble_cnt !== NW'(m_bub)) begin
            n_errors++;
            $display("FAIL bubble_cnt: got %0d, expected %0d", bubble_cnt, m_bub);
        end
        if (m_occ > 0) begin
            n_checks++;
            if ({out_data, out_ctrl} !== sb[0]) begin
                n_errors++;
                $display("FAIL head_beat: got %h, expected %h", {out_data, out_ctrl}, sb[0]);
            end
        end else begin
            n_checks++;
            if (out_ctrl !== '0) begin
                n_errors++;
                $display("FAIL idle_ctrl: got %h, expected 0000", out_ctrl);
            end
        end
        if (was_flush) begin
            n_checks++;
            if (out_data !== '0) begin
                n_errors++;
                $display("FAIL flush_data: got %h, expected 0", out_data);
            end
        end
        accepted = acc;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        bit a;
        in_valid  = 1'b1;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        cycle(a);
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        in_valid  = 1'b0;
        out_ready = ordy;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 ||
            occupancy !== 2'd0 || bubble_cnt !== '0 || out_data !== '0) begin
            n_errors++;
            $display("FAIL %s: got valid=%b ctrl=%h rdy=%b occ=%0d bub=%0d data=%h, expected 0 0000 1 0 0 0",
                     tag, out_valid, out_ctrl, in_ready, occupancy, bubble_cnt, out_data);
        end
    endtask

    task automatic test_reset();
        #3;
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("reset released");
    endtask

    task automatic test_saturation();
        idle(20, 1'b1);
        n_checks++;
        if (bubble_cnt !== 4'd15) begin
            n_errors++;
            $display("FAIL bubble_saturate: got %0d, expected 15", bubble_cnt);
        end
        for (int i = 0; i < 3; i++) send(DW'(32'h100 + i), 16'h0001, 1'b1);
        idle(2, 1'b1);
        n_checks++;
        if (bubble_cnt !== 4'd15) begin
            n_errors++;
            $display("FAIL bubble_hold_sat: got %0d, expected 15", bubble_cnt);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_streaming();
        bit a;
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = 16'h0001;
            cycle(a);
        end
        idle(3, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit a;
        int guard;
        send(32'hA0, 16'h0011, 1'b1);
        send(32'hB0, 16'h0022, 1'b0);
        send(32'hC0, 16'h0033, 1'b0);
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA0) begin
            n_errors++;
            $display("FAIL skid_full: got occ=%0d rdy=%b data=%h, expected 2 0 000000a0",
                     occupancy, in_ready, out_data);
        end
        a = 1'b0;
        guard = 0;
        while (!a && guard < 5) begin
            in_valid  = 1'b1;
            in_data   = 32'hC0;
            in_ctrl   = 16'h0033;
            out_ready = 1'b1;
            cycle(a);
            guard++;
        end
        if (!a) begin
            n_errors++;
            $display("FAIL c_accept_timeout: got no accept, expected accept within 5 cycles");
        end
        idle(3, 1'b1);
    endtask

    task automatic test_hold();
        bit a;
        send(32'h1A, 16'h0101, 1'b0);
        send(32'h1B, 16'h0202, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_data   = 32'hDEAD;
            in_ctrl   = 16'h0303;
            out_ready = 1'b1;
            cycle(a);
        end
        n_checks++;
        if (out_data !== 32'h1A || occupancy !== 2'd2) begin
            n_errors++;
            $display("FAIL hold_frozen: got data=%h occ=%0d, expected 0000001a 2", out_data, occupancy);
        end
        hold = 1'b0;
        idle(3, 1'b1);
    endtask

    task automatic test_flush_hold();
        bit a;
        send(32'h2A, 16'h0404, 1'b0);
        send(32'h2B, 16'h0505, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h2C;
        in_ctrl   = 16'hFFFF;
        flush     = 1'b1;
        hold      = 1'b1;
        out_ready = 1'b0;
        cycle(a);
        flush    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 16'h0000 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_state: got valid=%b ctrl=%h occ=%0d rdy=%b, expected 0 0000 0 1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_async_reset();
        send(32'h3A, 16'h0606, 1'b0);
        send(32'h3B, 16'h0707, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        send(32'h3C, 16'h0808, 1'b1);
        idle(2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_streaming();
        test_back_to_back();
        test_hold();
        test_flush_hold();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got %0d beats left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
